// File: rtl/read_ack_ctrl.sv
// Host read-back and interrupt-acknowledge sequencer for an 8259-style controller.
// Presents register, poll and vector bytes on the data bus, and tells the core
// when an acknowledge (or poll read) starts and finishes.
module read_ack_ctrl #(
  localparam int unsigned DW = 8,
  localparam int unsigned LW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          CS,
  input  logic          RD,
  input  logic          A0,
  input  logic          INTA,
  input  logic [DW-1:0] ICW1,
  input  logic [DW-1:0] ICW2,
  input  logic [DW-1:0] ICW4,
  input  logic [DW-1:0] OCW3,
  input  logic          OCW3_wr,
  input  logic [DW-1:0] IRR,
  input  logic [DW-1:0] ISR,
  input  logic [DW-1:0] IMR,
  input  logic          int_pending,
  input  logic [LW-1:0] level,
  output logic [DW-1:0] Data_out,
  output logic          Data_oe,
  output logic          ack_first,
  output logic          ack_done,
  output logic [LW-1:0] ack_level
);

  localparam logic [LW-1:0] SPURIOUS_LEVEL = LW'(7);
  localparam logic [DW-1:0] CALL_OPCODE    = DW'(8'hCD);

  typedef enum logic [1:0] {IDLE, ACK1, ACK2, ACK3} state_t;

  // What the bus is currently carrying; the byte itself is formed live from it.
  typedef enum logic [3:0] {
    SRC_NONE, SRC_IRR, SRC_ISR, SRC_IMR, SRC_POLL,
    SRC_CD, SRC_LOW, SRC_ICW2, SRC_VEC86
  } src_t;

  state_t          state, state_n;
  src_t            src, src_n;
  logic            rd_q, inta_q;
  logic            read_sel, read_sel_n;      // 0: IRR, 1: ISR
  logic            poll_req, poll_req_n;
  logic            host_rd, host_rd_n;        // accepted host read still in progress
  logic            poll_rd, poll_rd_n;        // that read is a poll read
  logic            poll_pend, poll_pend_n;    // int_pending captured for the poll byte
  logic [LW-1:0]   ack_level_n;
  logic            data_oe_n, ack_first_n, ack_done_n;

  logic rd_fall, rd_rise, inta_fall, inta_rise, mode_8086;
  logic unused_bits;

  assign rd_fall   = rd_q & ~RD;
  assign rd_rise   = ~rd_q & RD;
  assign inta_fall = inta_q & ~INTA;
  assign inta_rise = ~inta_q & INTA;
  assign mode_8086 = ICW4[0];
  assign unused_bits = ^{ICW1[4:3], ICW1[1:0], ICW4[7:1], OCW3[7:3]};

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      src       <= SRC_NONE;
      rd_q      <= 1'b1;
      inta_q    <= 1'b1;
      read_sel  <= 1'b0;
      poll_req  <= 1'b0;
      host_rd   <= 1'b0;
      poll_rd   <= 1'b0;
      poll_pend <= 1'b0;
      ack_level <= '0;
      Data_oe   <= 1'b0;
      ack_first <= 1'b0;
      ack_done  <= 1'b0;
    end else begin
      state     <= state_n;
      src       <= src_n;
      rd_q      <= RD;
      inta_q    <= INTA;
      read_sel  <= read_sel_n;
      poll_req  <= poll_req_n;
      host_rd   <= host_rd_n;
      poll_rd   <= poll_rd_n;
      poll_pend <= poll_pend_n;
      ack_level <= ack_level_n;
      Data_oe   <= data_oe_n;
      ack_first <= ack_first_n;
      ack_done  <= ack_done_n;
    end
  end

  // Next-state and registered-output decode; INTA always takes priority over RD.
  always_comb begin
    state_n     = state;
    src_n       = src;
    read_sel_n  = read_sel;
    poll_req_n  = poll_req;
    host_rd_n   = host_rd;
    poll_rd_n   = poll_rd;
    poll_pend_n = poll_pend;
    ack_level_n = ack_level;
    data_oe_n   = Data_oe;
    ack_first_n = 1'b0;
    ack_done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (inta_fall) begin
          state_n     = ACK1;
          ack_first_n = 1'b1;
          ack_level_n = int_pending ? level : SPURIOUS_LEVEL;
          src_n       = mode_8086 ? SRC_NONE : SRC_CD;
          data_oe_n   = ~mode_8086;
          host_rd_n   = 1'b0;
          poll_rd_n   = 1'b0;
        end else begin
          if (host_rd && rd_rise) begin
            host_rd_n = 1'b0;
            poll_rd_n = 1'b0;
            if (poll_rd) begin
              poll_req_n = 1'b0;
              ack_done_n = poll_pend;
            end
          end
          if (Data_oe && (RD || CS)) begin
            data_oe_n = 1'b0;
            src_n     = SRC_NONE;
          end
          if (rd_fall && !CS) begin
            host_rd_n = 1'b1;
            data_oe_n = 1'b1;
            if (poll_req) begin
              poll_rd_n   = 1'b1;
              poll_pend_n = int_pending;
              ack_level_n = level;
              src_n       = SRC_POLL;
            end else if (A0) begin
              src_n = SRC_IMR;
            end else begin
              src_n = read_sel ? SRC_ISR : SRC_IRR;
            end
          end
        end
      end
      ACK1: begin
        if (INTA) data_oe_n = 1'b0;
        if (inta_fall) begin
          state_n   = ACK2;
          src_n     = mode_8086 ? SRC_VEC86 : SRC_LOW;
          data_oe_n = 1'b1;
        end
      end
      ACK2: begin
        if (INTA) data_oe_n = 1'b0;
        if (mode_8086) begin
          if (inta_rise) begin
            state_n    = IDLE;
            src_n      = SRC_NONE;
            ack_done_n = 1'b1;
          end
        end else if (inta_fall) begin
          state_n   = ACK3;
          src_n     = SRC_ICW2;
          data_oe_n = 1'b1;
        end
      end
      ACK3: begin
        if (INTA) data_oe_n = 1'b0;
        if (inta_rise) begin
          state_n    = IDLE;
          src_n      = SRC_NONE;
          ack_done_n = 1'b1;
        end
      end
    endcase

    // A control-word write lands last so it wins over a same-cycle poll clear.
    if (OCW3_wr) begin
      if (OCW3[1]) read_sel_n = OCW3[0];
      if (OCW3[2]) poll_req_n = 1'b1;
    end
  end

  // Bus byte: register sources pass through live, vector bytes use the latched level.
  always_comb begin
    Data_out = '0;
    if (Data_oe) begin
      case (src)
        SRC_IRR:   Data_out = IRR;
        SRC_ISR:   Data_out = ISR;
        SRC_IMR:   Data_out = IMR;
        SRC_POLL:  Data_out = {poll_pend, 4'b0000, ack_level};
        SRC_CD:    Data_out = CALL_OPCODE;
        SRC_LOW:   Data_out = ICW1[2] ? {ICW1[7:5], ack_level, 2'b00}
                                      : {ICW1[7:6], ack_level, 3'b000};
        SRC_ICW2:  Data_out = ICW2;
        SRC_VEC86: Data_out = {ICW2[7:3], ack_level};
        default:   Data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_read_ack_ctrl.sv
// Self-checking bench for read_ack_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a bus-level model.
module tb_read_ack_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       CS, RD, A0, INTA, OCW3_wr, int_pending;
  logic [7:0] ICW1, ICW2, ICW4, OCW3, IRR, ISR, IMR;
  logic [2:0] level;
  logic [7:0] Data_out;
  logic       Data_oe, ack_first, ack_done;
  logic [2:0] ack_level;

  int checks = 0;
  int errors = 0;

  read_ack_ctrl dut (
    .clk(clk), .reset(reset), .CS(CS), .RD(RD), .A0(A0), .INTA(INTA),
    .ICW1(ICW1), .ICW2(ICW2), .ICW4(ICW4), .OCW3(OCW3), .OCW3_wr(OCW3_wr),
    .IRR(IRR), .ISR(ISR), .IMR(IMR), .int_pending(int_pending), .level(level),
    .Data_out(Data_out), .Data_oe(Data_oe), .ack_first(ack_first),
    .ack_done(ack_done), .ack_level(ack_level)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Acknowledge tracked as "number of INTA falls seen so far" (0 = not acknowledging).
  int         m_acks;
  logic       m_rd_q, m_inta_q, m_sel_isr, m_poll, m_oe, m_first, m_done;
  logic       m_in_read, m_is_poll, m_a0, m_isr, m_pend;
  logic [2:0] m_level;

  function automatic logic [7:0] vec_byte(input int k);
    if (ICW4[0]) return {ICW2[7:3], m_level};
    if (k == 1) return 8'hCD;
    if (k == 2) return ICW1[2] ? {ICW1[7:5], m_level, 2'b00} : {ICW1[7:6], m_level, 3'b000};
    return ICW2;
  endfunction

  function automatic logic [7:0] exp_data();
    if (!m_oe) return 8'h00;
    if (m_acks > 0) return vec_byte(m_acks);
    if (m_is_poll) return {m_pend, 4'b0000, m_level};
    if (m_a0) return IMR;
    return m_isr ? ISR : IRR;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_acks <= 0; m_rd_q <= 1'b1; m_inta_q <= 1'b1; m_sel_isr <= 1'b0;
      m_poll <= 1'b0; m_oe <= 1'b0; m_first <= 1'b0; m_done <= 1'b0;
      m_in_read <= 1'b0; m_is_poll <= 1'b0; m_a0 <= 1'b0; m_isr <= 1'b0;
      m_pend <= 1'b0; m_level <= 3'd0;
    end else begin
      m_rd_q <= RD; m_inta_q <= INTA; m_first <= 1'b0; m_done <= 1'b0;
      if (m_acks == 0) begin
        if (m_inta_q && !INTA) begin
          m_acks <= 1; m_first <= 1'b1; m_in_read <= 1'b0;
          m_level <= int_pending ? level : 3'd7;
          m_oe <= !ICW4[0];
        end else begin
          if (m_in_read && !m_rd_q && RD) begin
            m_in_read <= 1'b0;
            if (m_is_poll) begin m_poll <= 1'b0; m_done <= m_pend; end
          end
          if (m_oe && (RD || CS)) m_oe <= 1'b0;
          if (m_rd_q && !RD && !CS) begin
            m_in_read <= 1'b1; m_oe <= 1'b1; m_is_poll <= m_poll;
            m_a0 <= A0; m_isr <= m_sel_isr;
            if (m_poll) begin m_pend <= int_pending; m_level <= level; end
          end
        end
      end else begin
        if (INTA) m_oe <= 1'b0;
        if (m_inta_q && !INTA) begin m_acks <= m_acks + 1; m_oe <= 1'b1; end
        if (!m_inta_q && INTA && m_acks == (ICW4[0] ? 2 : 3)) begin
          m_acks <= 0; m_done <= 1'b1;
        end
      end
      if (OCW3_wr) begin
        if (OCW3[1]) m_sel_isr <= OCW3[0];
        if (OCW3[2]) m_poll <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    cmp("model_data_out", Data_out, exp_data());
    cmp("model_data_oe", 8'(Data_oe), 8'(m_oe));
    cmp("model_ack_first", 8'(ack_first), 8'(m_first));
    cmp("model_ack_done", 8'(ack_done), 8'(m_done));
    cmp("model_ack_level", 8'(ack_level), 8'(m_level));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic inta_pulse_low();
    INTA = 1'b0; tick();
  endtask

  initial begin
    logic [7:0] v80 [3];
    v80 = '{8'hCD, 8'h14, 8'h20};

    reset = 1'b1;
    ICW1 = 8'h16; ICW2 = 8'h48; ICW4 = 8'h01; OCW3 = 8'h00; OCW3_wr = 1'b0;
    IRR = 8'h00; ISR = 8'h00; IMR = 8'h00; int_pending = 1'b0; level = 3'd0;
    CS = 1'b1; RD = 1'b1; A0 = 1'b0; INTA = 1'b1;
    tick(); tick();
    cmp("reset_data_out", Data_out, 8'h00);
    cmp("reset_data_oe", 8'(Data_oe), 8'h00);
    cmp("reset_ack_first", 8'(ack_first), 8'h00);
    cmp("reset_ack_done", 8'(ack_done), 8'h00);
    cmp("reset_ack_level", 8'(ack_level), 8'h00);
    reset = 1'b0; tick();

    // Register reads: ISR selected, then IMR, live pass-through mid-read.
    OCW3 = 8'h0B; OCW3_wr = 1'b1; tick();
    OCW3_wr = 1'b0; IRR = 8'h21; ISR = 8'h04; CS = 1'b0; A0 = 1'b0; RD = 1'b0; tick();
    cmp("isr_read", Data_out, 8'h04);
    cmp("isr_read_oe", 8'(Data_oe), 8'h01);
    ISR = 8'h44; #1;
    cmp("isr_passthrough", Data_out, 8'h44);
    RD = 1'b1; tick();
    cmp("read_end_oe", 8'(Data_oe), 8'h00);
    A0 = 1'b1; IMR = 8'hF0; RD = 1'b0; tick();
    cmp("imr_read", Data_out, 8'hF0);
    RD = 1'b1; CS = 1'b1; tick();

    // 8086 acknowledge.
    ICW4 = 8'h01; ICW2 = 8'h48; int_pending = 1'b1; level = 3'd3;
    inta_pulse_low();
    cmp("x86_ack_first", 8'(ack_first), 8'h01);
    cmp("x86_ack1_oe", 8'(Data_oe), 8'h00);
    cmp("x86_ack_level", 8'(ack_level), 8'h03);
    INTA = 1'b1; tick();
    cmp("x86_ack_first_clr", 8'(ack_first), 8'h00);
    inta_pulse_low();
    cmp("x86_vector", Data_out, 8'h4B);
    cmp("x86_done_early", 8'(ack_done), 8'h00);
    level = 3'd0; #1;
    cmp("x86_vector_latched", Data_out, 8'h4B);
    INTA = 1'b1; tick();
    cmp("x86_ack_done", 8'(ack_done), 8'h01);
    cmp("x86_oe_drop", 8'(Data_oe), 8'h00);
    tick();
    cmp("x86_ack_done_clr", 8'(ack_done), 8'h00);

    // 8080 acknowledge, three bytes.
    ICW4 = 8'h00; ICW1 = 8'h16; ICW2 = 8'h20; level = 3'd5; int_pending = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inta_pulse_low();
      cmp("x80_byte", Data_out, v80[k]);
      cmp("x80_oe", 8'(Data_oe), 8'h01);
      INTA = 1'b1; tick();
      cmp("x80_oe_gap", 8'(Data_oe), 8'h00);
      cmp("x80_ack_done", 8'(ack_done), (k == 2) ? 8'h01 : 8'h00);
    end
    tick();

    // Poll read, then an ordinary IRR read.
    OCW3 = 8'h0A; OCW3_wr = 1'b1; tick();
    OCW3 = 8'h0C; tick();
    OCW3_wr = 1'b0; level = 3'd6; int_pending = 1'b1; IRR = 8'h5A;
    CS = 1'b0; A0 = 1'b1; RD = 1'b0; tick();
    cmp("poll_byte", Data_out, 8'h86);
    cmp("poll_level", 8'(ack_level), 8'h06);
    RD = 1'b1; tick();
    cmp("poll_ack_done", 8'(ack_done), 8'h01);
    tick();
    A0 = 1'b0; RD = 1'b0; tick();
    cmp("after_poll_irr", Data_out, 8'h5A);
    RD = 1'b1; CS = 1'b1; tick();
    cmp("after_poll_no_done", 8'(ack_done), 8'h00);

    // Spurious acknowledge.
    ICW4 = 8'h01; ICW2 = 8'h08; int_pending = 1'b0; level = 3'd2;
    inta_pulse_low();
    cmp("spurious_level", 8'(ack_level), 8'h07);
    INTA = 1'b1; tick();
    inta_pulse_low();
    cmp("spurious_vector", Data_out, 8'h0F);
    INTA = 1'b1; tick();
    cmp("spurious_done", 8'(ack_done), 8'h01);

    // Reset between INTA pulses, then a clean sequence.
    ICW2 = 8'h48; int_pending = 1'b1; level = 3'd1;
    inta_pulse_low();
    INTA = 1'b1; tick();
    reset = 1'b1; tick();
    cmp("rst_mid_oe", 8'(Data_oe), 8'h00);
    cmp("rst_mid_done", 8'(ack_done), 8'h00);
    reset = 1'b0; tick();
    cmp("rst_mid_done2", 8'(ack_done), 8'h00);
    inta_pulse_low();
    cmp("rst_fresh_first", 8'(ack_first), 8'h01);
    INTA = 1'b1; tick();
    inta_pulse_low();
    cmp("rst_fresh_vector", Data_out, 8'h49);
    INTA = 1'b1; tick();
    cmp("rst_fresh_done", 8'(ack_done), 8'h01);

    // RD and INTA fall together: INTA wins, RD needs a fresh falling edge.
    CS = 1'b0; A0 = 1'b1; IMR = 8'h3C; RD = 1'b0; INTA = 1'b0; tick();
    cmp("tie_ack_first", 8'(ack_first), 8'h01);
    cmp("tie_oe", 8'(Data_oe), 8'h00);
    INTA = 1'b1; tick();
    inta_pulse_low();
    cmp("tie_vector", Data_out, 8'h49);
    INTA = 1'b1; tick();
    tick();
    cmp("tie_rd_held_oe", 8'(Data_oe), 8'h00);
    RD = 1'b1; tick();
    RD = 1'b0; tick();
    cmp("tie_new_read", Data_out, 8'h3C);
    RD = 1'b1; CS = 1'b1; tick();

    // Randomized traffic; the every-cycle model comparison does the checking.
    for (int b = 0; b < 8; b++) begin
      reset = 1'b1;
      ICW4 = 8'($urandom);
      ICW1 = 8'($urandom); ICW2 = 8'($urandom);
      RD = 1'b1; INTA = 1'b1; CS = 1'b1; OCW3_wr = 1'b0;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(3) == 0) RD = ~RD;
        if ($urandom_range(5) == 0) INTA = ~INTA;
        if ($urandom_range(7) == 0) CS = ~CS;
        A0 = 1'($urandom);
        OCW3_wr = ($urandom_range(15) == 0);
        OCW3 = 8'($urandom);
        if ($urandom_range(3) == 0) begin
          IRR = 8'($urandom); ISR = 8'($urandom); IMR = 8'($urandom);
        end
        if ($urandom_range(31) == 0) begin ICW1 = 8'($urandom); ICW2 = 8'($urandom); end
        int_pending = 1'($urandom);
        level = 3'($urandom);
        reset = ($urandom_range(199) == 0);
        tick();
      end
    end

    reset = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_ack_ctrl.md
READ_ACK_CTRL -- requirements
Module: read_ack_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 CS, RD, A0  in  1 each  host chip select (active-low), read strobe (active-low), address bit.
REQ-005 INTA  in  1  interrupt-acknowledge strobe, active-low, not qualified by CS.
REQ-006 ICW1, ICW2, ICW4, OCW3  in  8 each  programmed control words from the write path.
REQ-007 OCW3_wr  in  1  one-clk pulse when OCW3 is written.
REQ-008 IRR, ISR, IMR  in  8 each  live interrupt request, in-service, mask registers.
REQ-009 int_pending  in  1; level  in  3  highest-priority unmasked request and its number.
REQ-010 Data_out  out  8  read/vector byte; Data_oe  out  1  bus drive enable.
REQ-011 ack_first  out  1  one-clk pulse at first INTA falling edge (core sets ISR bit, clears IRR bit).
REQ-012 ack_done  out  1  one-clk pulse at end of acknowledge or poll read; ack_level  out  3  latched level.

Function
REQ-013 RD and INTA SHALL be registered each clk (rd_q, inta_q); falling edge = q high and input low; rising edge = q low and input high.
REQ-014 read_sel SHALL update on OCW3_wr when OCW3[1]=1: OCW3[0]=0 selects IRR, 1 selects ISR; OCW3[1]=0 leaves it unchanged.
REQ-015 poll_req SHALL set on OCW3_wr with OCW3[2]=1 and clear at the next host read rising edge.
REQ-016 Host read: on RD falling edge with CS=0 and FSM in IDLE, Data_out/Data_oe SHALL update at that same clk edge; Data_oe held until first clk where RD=1 or CS=1.
REQ-017 Host read data: poll_req=1 -> {int_pending,4'b0000,level} regardless of A0; else A0=1 -> IMR; else A0=0 -> IRR or ISR per read_sel.
REQ-018 A poll read SHALL latch level into ack_level on RD falling edge and, if int_pending=1, pulse ack_done at RD rising edge.
REQ-019 FSM states: IDLE, ACK1, ACK2, ACK3; transitions only on INTA falling edges, return to IDLE on the rising edge ending the final pulse.
REQ-020 IDLE->ACK1 on INTA falling: pulse ack_first; latch ack_level = level if int_pending=1 else 3'd7 (spurious).
REQ-021 8086 mode (ICW4[0]=1): ACK1 drives nothing (Data_oe=0); second falling ->ACK2, Data_out={ICW2[7:3],ack_level}, Data_oe=1; ACK2 rising -> ack_done pulse, IDLE.
REQ-022 8080 mode (ICW4[0]=0): ACK1 drives 8'hCD; ACK2 drives low address; ACK3 drives ICW2; ACK3 rising -> ack_done pulse, IDLE.
REQ-023 8080 low address: ICW1[2]=1 -> {ICW1[7:5],ack_level,2'b00}; ICW1[2]=0 -> {ICW1[7:6],ack_level,3'b000}.
REQ-024 During ACK* states Data_oe SHALL drop at the clk where INTA=1 and rise again at next falling edge.
REQ-025 Simultaneous RD and INTA falling edges: INTA wins; RD ignored until FSM returns to IDLE and a new RD falling edge occurs.
REQ-026 Host RD in non-IDLE states SHALL not drive the bus nor alter poll_req.
REQ-027 Changes of ICW/IRR/ISR inputs mid-read SHALL pass through to Data_out combinationally while Data_oe=1 for register reads; vector bytes use latched ack_level.

Reset
REQ-028 On reset: FSM=IDLE, rd_q=inta_q=1, read_sel=IRR, poll_req=0, ack_level=0, Data_out=8'h00, Data_oe=0, ack_first=ack_done=0.
REQ-029 Reset asserted mid-acknowledge SHALL abort the sequence with no ack_done pulse; first INTA falling after release starts a fresh ACK1.

Verification
REQ-030 OCW3_wr with OCW3=8'h0B, IRR=8'h21, ISR=8'h04, CS=0 A0=0 RD low -> Data_out=8'h04, Data_oe=1 same clk; A0=1 IMR=8'hF0 -> 8'hF0.
REQ-031 ICW4=8'h01, ICW2=8'h48, int_pending=1 level=3, two INTA pulses -> ack_first on 1st, Data_out=8'h4B only during 2nd, ack_done after 2nd rising.
REQ-032 ICW4=8'h00, ICW1=8'h16 (ADI=1), ICW2=8'h20, level=5, three INTA pulses -> bytes 8'hCD, 8'h14, 8'h20; ack_done once.
REQ-033 OCW3=8'h0C written, level=6 int_pending=1, RD pulse -> Data_out=8'h86, ack_done at RD rising; next RD returns IRR.
REQ-034 int_pending=0 at first INTA (8086, ICW2=8'h08) -> vector 8'h0F.
REQ-035 Reset asserted between INTA pulses -> Data_oe=0, no ack_done; next two INTA pulses complete a normal sequence.
